receptor_dac: RTL and testbench
===============================

RECEPTOR_DAC -- requirements
Module: receptor_dac

Interface
REQ-001 Parameter N_ADC, 12, width of the recovered sample.
REQ-002 Parameter N_TRAMA, 16, bits per serial frame.
REQ-003 Port Clock, input, 1, system clock; all logic SHALL be clocked on its rising edge (one clock only).
REQ-004 Port reset, input, 1, asynchronous, active-low reset.
REQ-005 Port SClk, input, 1, serial bit clock from the DAC transmitter; asynchronous to Clock.
REQ-006 Port Sync, input, 1, active-low frame strobe from the transmitter.
REQ-007 Port Data_DAC, input, 1, serial data, MSB first.
REQ-008 Port Dato, output, N_ADC, last complete frame bits [11:0].
REQ-009 Port Modo, output, 2, last complete frame bits [13:12] (power-down mode field).
REQ-010 Port done, output, 1, one-Clock pulse when Dato/Modo update.
REQ-011 Port error_trama, output, 1, one-Clock pulse on a short frame.
REQ-012 Port ocupado, output, 1, high while a frame is being received.
REQ-013 Port tramas, output, 8, count of good frames, wraps 255->0.

Function
REQ-014 SClk, Sync and Data_DAC SHALL each pass through an identical 2-flop synchronizer, plus one history flop for edge detection on SClk and Sync.
REQ-015 SClk high and low times SHALL be at least 4 Clock periods; behaviour outside this is unspecified.
REQ-016 Bits SHALL be sampled from synchronized Data_DAC on each detected SClk falling edge while synchronized Sync is low.
REQ-017 FSM states: ESPERA, RECIBE, FIN.
REQ-018 ESPERA: on detected Sync falling edge -> RECIBE, bit counter cleared to 0, shift register cleared.
REQ-019 RECIBE: each SClk falling edge shifts one bit in (MSB first) and increments the counter.
REQ-020 RECIBE: when the 16th bit is shifted, Dato<=shift[11:0], Modo<=shift[13:12], done=1 for one cycle, tramas+=1, -> FIN; bits [15:14] are discarded.
REQ-021 RECIBE: detected Sync rising edge with fewer than 16 bits -> error_trama=1 for one cycle, Dato/Modo/tramas unchanged, -> ESPERA.
REQ-022 Sync rising and the 16th SClk falling edge detected in the same cycle: the frame SHALL complete (REQ-020); error_trama SHALL stay 0.
REQ-023 FIN: further SClk edges are ignored without error; detected Sync high -> ESPERA.
REQ-024 ocupado SHALL be 1 exactly while in RECIBE.
REQ-025 Latency: done SHALL rise on the 2nd Clock edge after the edge at which the first synchronizer flop captures SClk low for the 16th bit.
REQ-026 done and error_trama SHALL never both be 1 in the same cycle.
REQ-027 A Sync level already low at reset release SHALL NOT start a frame; Sync history flop resets to 0.

Reset
REQ-028 While reset=0: Dato=0, Modo=0, done=0, error_trama=0, ocupado=0, tramas=0, FSM=ESPERA, counter=0, shift=0, synchronizers=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without a done or error_trama pulse.

Verification
REQ-030 Frame 0x0ABC, SClk=Clock/8 -> Dato=0xABC, Modo=00, one done pulse at REQ-025 latency, tramas=1.
REQ-031 Frame 0x3FFF after REQ-030 -> Dato=0xFFF, Modo=11, tramas=2.
REQ-032 Sync low, 10 bits, Sync high -> one error_trama pulse, Dato stays 0xFFF, tramas stays 2, ocupado falls.
REQ-033 Frame of 20 SClk edges with first 16 bits 0x0555 -> one done, Dato=0x555, extra 4 bits ignored, no error.
REQ-034 reset=0 after 8 bits, release, then frame 0x0123 -> no pulse during the reset, then Dato=0x123, tramas=1.
REQ-035 256 good frames from reset -> tramas=0x00, 256 done pulses; Sync rising coincident with 16th edge -> done, no error_trama.

Source files
------------

// File: rtl/receptor_dac_if.sv
// Serial link from the DAC-style transmitter: bit clock, active-low frame strobe, data.
interface receptor_dac_if;
  logic SClk;
  logic Sync;
  logic Data_DAC;

  modport master (output SClk, output Sync, output Data_DAC);
  modport slave  (input  SClk, input  Sync, input  Data_DAC);
endinterface

// File: rtl/receptor_dac.sv
// Serial frame receiver: synchronizes SClk/Sync/Data_DAC into Clock, shifts in
// MSB-first frames and publishes the sample and power-down mode on completion.
module receptor_dac #(
  parameter int N_ADC   = 12,
  parameter int N_TRAMA = 16
) (
  input  logic               Clock,
  input  logic               reset,
  receptor_dac_if.slave      ser,
  output logic [N_ADC-1:0]   Dato,
  output logic [1:0]         Modo,
  output logic               done,
  output logic               error_trama,
  output logic               ocupado,
  output logic [7:0]         tramas
);

  localparam int                CNT_W  = $clog2(N_TRAMA + 1);
  localparam logic [CNT_W-1:0]  ULTIMO = CNT_W'(N_TRAMA - 1);

  typedef enum logic [1:0] {ESPERA, RECIBE, FIN} estado_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_sync, sync_sync, data_sync;
  logic       sclk_hist, sync_hist;

  // NOTE: history flops reset to 0 so a Sync already low at release never looks like a falling edge.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      sync_sync <= '0;
      data_sync <= '0;
      sclk_hist <= 1'b0;
      sync_hist <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the previous stage's old value.
      sclk_sync <= {sclk_sync[0], ser.SClk};
      sync_sync <= {sync_sync[0], ser.Sync};
      data_sync <= {data_sync[0], ser.Data_DAC};
      sclk_hist <= sclk_sync[1];
      sync_hist <= sync_sync[1];
    end
  end

  logic sclk_fall, sync_fall, sync_rise, data_s, sync_s;

  assign sync_s    = sync_sync[1];
  assign data_s    = data_sync[1];
  assign sclk_fall = sclk_hist & ~sclk_sync[1];
  assign sync_fall = sync_hist & ~sync_s;
  assign sync_rise = ~sync_hist & sync_s;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  estado_t              state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [N_TRAMA-1:0]   shift, shift_next;
  logic [N_ADC-1:0]     dato_next;
  logic [1:0]           modo_next;
  logic [7:0]           tramas_next;
  logic                 done_next, error_next;
  logic                 ultimo_bit;

  assign ultimo_bit = sclk_fall && (cnt == ULTIMO);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_next  = state;
    cnt_next    = cnt;
    shift_next  = shift;
    dato_next   = Dato;
    modo_next   = Modo;
    tramas_next = tramas;
    done_next   = 1'b0;
    error_next  = 1'b0;

    case (state)
      ESPERA: begin
        if (sync_fall) begin
          state_next = RECIBE;
          cnt_next   = '0;
          shift_next = '0;
        end
      end
      RECIBE: begin
        if (sclk_fall) begin
          shift_next = {shift[N_TRAMA-2:0], data_s};
          cnt_next   = cnt + 1'b1;
        end
        // Completion wins over a coincident Sync rise.
        if (ultimo_bit) begin
          dato_next   = shift_next[N_ADC-1:0];
          modo_next   = shift_next[N_ADC+1:N_ADC];
          tramas_next = tramas + 8'd1;
          done_next   = 1'b1;
          state_next  = FIN;
        end else if (sync_rise) begin
          error_next  = 1'b1;
          state_next  = ESPERA;
        end
      end
      FIN: begin
        if (sync_s) state_next = ESPERA;
      end
      default: state_next = ESPERA;
    endcase
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state       <= ESPERA;
      cnt         <= '0;
      shift       <= '0;
      Dato        <= '0;
      Modo        <= '0;
      tramas      <= '0;
      done        <= 1'b0;
      error_trama <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      shift       <= shift_next;
      Dato        <= dato_next;
      Modo        <= modo_next;
      tramas      <= tramas_next;
      done        <= done_next;
      error_trama <= error_next;
    end
  end

  assign ocupado = (state == RECIBE);

endmodule

// File: tb/tb_receptor_dac.sv
// Directed bench for receptor_dac: good, short, long, aborted and coincident frames,
// tramas wrap, and done latency measured in Clock cycles from the 16th SClk fall.
module tb_receptor_dac;

  logic        Clock;
  logic        reset;
  logic [11:0] Dato;
  logic [1:0]  Modo;
  logic        done, error_trama, ocupado;
  logic [7:0]  tramas;

  receptor_dac_if ser ();

  receptor_dac #(.N_ADC(12), .N_TRAMA(16)) dut (
    .Clock       (Clock),
    .reset       (reset),
    .ser         (ser.slave),
    .Dato        (Dato),
    .Modo        (Modo),
    .done        (done),
    .error_trama (error_trama),
    .ocupado     (ocupado),
    .tramas      (tramas)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and pulse monitors, sampled on the falling edge.
  int   cyc = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   done_cyc = 0;
  int   fall_cyc = 0;
  logic done_q = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (done)                done_cnt <= done_cnt + 1;
    if (error_trama)         err_cnt  <= err_cnt + 1;
    if (done && error_trama) both_cnt <= both_cnt + 1;
    if (done && !done_q)     done_cyc <= cyc;
    done_q <= done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  // SClk half period is 4 Clock cycles (SClk = Clock/8); data changes while SClk is high.
  task automatic send_frame(input logic [15:0] w, input int nbits,
                            input bit sync_with_last, input bit keep_low);
    ser.Sync = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      ser.Data_DAC = (i < 16) ? w[15-i] : 1'b0;
      tick(4);
      ser.SClk = 1'b0;
      if (i == 15) fall_cyc = cyc;
      if (sync_with_last && i == nbits - 1) ser.Sync = 1'b1;
      if (i == 4) check("ocupado_mid_frame", 32'(ocupado), 32'd1);
      tick(4);
      ser.SClk = 1'b1;
    end
    if (!keep_low) begin
      if (!sync_with_last) begin
        tick(4);
        ser.Sync = 1'b1;
      end
      tick(8);
    end
  endtask

  int d0, e0;

  initial begin
    reset        = 1'b0;
    ser.SClk     = 1'b1;
    ser.Sync     = 1'b0;
    ser.Data_DAC = 1'b0;
    tick(3);

    check("rst_dato",    32'(Dato),        32'h0);
    check("rst_modo",    32'(Modo),        32'h0);
    check("rst_done",    32'(done),        32'h0);
    check("rst_error",   32'(error_trama), 32'h0);
    check("rst_ocupado", 32'(ocupado),     32'h0);
    check("rst_tramas",  32'(tramas),      32'h0);

    // Sync held low across reset release must not open a frame.
    reset = 1'b1;
    tick(20);
    check("sync_low_at_release_ocupado", 32'(ocupado), 32'd0);
    ser.Sync = 1'b1;
    tick(8);
    check("sync_low_at_release_error", 32'(err_cnt), 32'd0);

    // Frame 0x0ABC with latency measurement.
    send_frame(16'h0ABC, 16, 1'b0, 1'b0);
    check("f1_dato",    32'(Dato),   32'hABC);
    check("f1_modo",    32'(Modo),   32'h0);
    check("f1_tramas",  32'(tramas), 32'd1);
    check("f1_done_cnt", 32'(done_cnt), 32'd1);
    check("f1_latency", 32'(done_cyc - fall_cyc), 32'd3);
    check("f1_ocupado_after", 32'(ocupado), 32'd0);

    // Frame 0x3FFF.
    send_frame(16'h3FFF, 16, 1'b0, 1'b0);
    check("f2_dato",     32'(Dato),     32'hFFF);
    check("f2_modo",     32'(Modo),     32'h3);
    check("f2_tramas",   32'(tramas),   32'd2);
    check("f2_done_cnt", 32'(done_cnt), 32'd2);

    // Short frame: 10 bits.
    send_frame(16'h1234, 10, 1'b0, 1'b0);
    check("short_error_cnt", 32'(err_cnt),  32'd1);
    check("short_done_cnt",  32'(done_cnt), 32'd2);
    check("short_dato",      32'(Dato),     32'hFFF);
    check("short_modo",      32'(Modo),     32'h3);
    check("short_tramas",    32'(tramas),   32'd2);
    check("short_ocupado",   32'(ocupado),  32'd0);

    // Long frame: 20 SClk edges, first 16 bits 0x0555.
    send_frame(16'h0555, 20, 1'b0, 1'b0);
    check("long_dato",      32'(Dato),     32'h555);
    check("long_modo",      32'(Modo),     32'h0);
    check("long_done_cnt",  32'(done_cnt), 32'd3);
    check("long_error_cnt", 32'(err_cnt),  32'd1);
    check("long_tramas",    32'(tramas),   32'd3);

    // Reset after 8 bits of a frame.
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(16'hFFFF, 8, 1'b0, 1'b1);
    reset = 1'b0;
    tick(4);
    check("midrst_dato",    32'(Dato),    32'h0);
    check("midrst_tramas",  32'(tramas),  32'd0);
    check("midrst_ocupado", 32'(ocupado), 32'd0);
    ser.Sync = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(8);
    check("midrst_no_done",  32'(done_cnt), 32'(d0));
    check("midrst_no_error", 32'(err_cnt),  32'(e0));
    send_frame(16'h0123, 16, 1'b0, 1'b0);
    check("postrst_dato",   32'(Dato),   32'h123);
    check("postrst_tramas", 32'(tramas), 32'd1);

    // 256 good frames from reset; the last has Sync rising with the 16th SClk fall.
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(4);
    d0 = done_cnt;
    e0 = err_cnt;
    for (int k = 0; k < 256; k++) begin
      if (k == 255) send_frame(16'h2F0F, 16, 1'b1, 1'b0);
      else          send_frame(16'(k * 257), 16, 1'b0, 1'b0);
    end
    check("wrap_tramas",     32'(tramas),          32'h00);
    check("wrap_done_cnt",   32'(done_cnt - d0),   32'd256);
    check("wrap_no_error",   32'(err_cnt - e0),    32'd0);
    check("coinc_dato",      32'(Dato),            32'hF0F);
    check("coinc_modo",      32'(Modo),            32'h2);
    check("coinc_latency",   32'(done_cyc - fall_cyc), 32'd3);
    check("never_both",      32'(both_cnt),        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
